// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_pkg;

   localparam int WORD_W         = 8;
   localparam int START_HOLD_DEF = 8;
   localparam int TIMEOUT_DEF    = 4096;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_START    = 2'd1,
      ST_WAIT_END = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational two-way round-robin requester select
module uart_rr_pick
   import uart_pkg::*;
(
   input  logic       req_a,
   input  logic       req_b,
   input  logic       last_b,
   output logic [1:0] grant
);

   // On a tie the requester not served last wins; a lone request always wins.
   always_comb begin
      grant = 2'b00;
      if (req_a && req_b) begin
         grant = last_b ? 2'b01 : 2'b10;
      end else if (req_a) begin
         grant = 2'b01;
      end else if (req_b) begin
         grant = 2'b10;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two-requester arbiter feeding a divided-clock UART transmitter
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int START_HOLD = START_HOLD_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              res,
   input  logic              req_a,
   input  logic [WORD_W-1:0] word_a,
   output logic              ack_a,
   input  logic              req_b,
   input  logic [WORD_W-1:0] word_b,
   output logic              ack_b,
   output logic [WORD_W-1:0] word_transmitter,
   output logic              TRANSMITTER_PRIZNAK,
   input  logic              priznak_end_transmitter,
   output logic              tx_done,
   output logic              tx_owner,
   output logic              timeout_err,
   output logic              busy
);

   localparam int HW = $clog2(START_HOLD + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(START_HOLD);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TO_MAX    = {TW{1'b1}};

   state_t        state;
   logic          last_b;
   logic [HW-1:0] hold_cnt;
   logic [TW-1:0] to_cnt;
   logic [2:0]    end_sync;
   logic          end_edge;
   logic [1:0]    grant;

   uart_rr_pick u_pick (
      .req_a  (req_a),
      .req_b  (req_b),
      .last_b (last_b),
      .grant  (grant)
   );

   // End flag crosses from the transmitter clock: two flops, plus one more for edge history.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         end_sync <= 3'b000;
      end else begin
         end_sync <= {end_sync[1:0], priznak_end_transmitter};
      end
   end

   assign end_edge = end_sync[1] & ~end_sync[2];

   // Frame sequencer: grant in IDLE, hold the strobe, wait for end-of-frame or give up.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state               <= ST_IDLE;
         ack_a               <= 1'b0;
         ack_b               <= 1'b0;
         word_transmitter    <= '0;
         TRANSMITTER_PRIZNAK <= 1'b0;
         tx_done             <= 1'b0;
         tx_owner            <= 1'b0;
         timeout_err         <= 1'b0;
         busy                <= 1'b0;
         last_b              <= 1'b1;
         hold_cnt            <= '0;
         to_cnt              <= '0;
      end else begin
         ack_a       <= 1'b0;
         ack_b       <= 1'b0;
         tx_done     <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant != 2'b00) begin
                  ack_a            <= grant[0];
                  ack_b            <= grant[1];
                  word_transmitter <= grant[1] ? word_b : word_a;
                  tx_owner         <= grant[1];
                  last_b           <= grant[1];
                  hold_cnt         <= '0;
                  busy             <= 1'b1;
                  state            <= ST_START;
               end
            end
            ST_START: begin
               // Strobe rises the cycle after the ack and stays up START_HOLD cycles.
               if (hold_cnt == HOLD_LAST) begin
                  TRANSMITTER_PRIZNAK <= 1'b0;
                  to_cnt              <= '0;
                  state               <= ST_WAIT_END;
               end else begin
                  TRANSMITTER_PRIZNAK <= 1'b1;
                  hold_cnt            <= hold_cnt + HW'(1);
               end
            end
            ST_WAIT_END: begin
               if (end_edge) begin
                  tx_done <= 1'b1;
                  state   <= ST_DONE;
               end else if (to_cnt == TO_LAST) begin
                  timeout_err <= 1'b1;
                  busy        <= 1'b0;
                  state       <= ST_IDLE;
               end else if (to_cnt != TO_MAX) begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               TRANSMITTER_PRIZNAK <= 1'b0;
               busy                <= 1'b0;
               state               <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

   localparam int SH = 8;
   localparam int TO = 50;

   typedef struct packed {
      logic       owner;
      logic [7:0] word;
   } grant_t;

   logic       clk = 1'b0;
   logic       res = 1'b0;
   logic       req_a = 1'b0;
   logic       req_b = 1'b0;
   logic [7:0] word_a = 8'h00;
   logic [7:0] word_b = 8'h00;
   logic       flag = 1'b0;
   logic       ack_a, ack_b, TRANSMITTER_PRIZNAK, tx_done, tx_owner, timeout_err, busy;
   logic [7:0] word_transmitter;

   grant_t grant_q[$];
   logic   done_q[$];
   int     to_expected = 0;
   int     vectors = 0;
   int     miscompares = 0;
   grant_t mon_g;
   logic   mon_o;

   uart_tx_arbiter #(.START_HOLD(SH), .TIMEOUT(TO)) dut (
      .clk                     (clk),
      .res                     (res),
      .req_a                   (req_a),
      .word_a                  (word_a),
      .ack_a                   (ack_a),
      .req_b                   (req_b),
      .word_b                  (word_b),
      .ack_b                   (ack_b),
      .word_transmitter        (word_transmitter),
      .TRANSMITTER_PRIZNAK     (TRANSMITTER_PRIZNAK),
      .priznak_end_transmitter (flag),
      .tx_done                 (tx_done),
      .tx_owner                (tx_owner),
      .timeout_err             (timeout_err),
      .busy                    (busy)
   );

   always #5 clk = ~clk;

   // Scoreboard: every ack, tx_done and timeout_err must match a queued expectation.
   always @(negedge clk) begin
      if (res) begin
         if (ack_a || ack_b) begin
            vectors++;
            if (grant_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_ack: ack_a=%0b ack_b=%0b word=%h, required no grant", ack_a, ack_b, word_transmitter);
            end else begin
               mon_g = grant_q.pop_front();
               if ({ack_b, ack_a} !== {mon_g.owner, ~mon_g.owner} || word_transmitter !== mon_g.word || tx_owner !== mon_g.owner) begin
                  miscompares++;
                  $display("FAIL grant: ack_b/ack_a=%b%b word=%h owner=%0b, required owner=%0b word=%h",
                           ack_b, ack_a, word_transmitter, tx_owner, mon_g.owner, mon_g.word);
               end
            end
         end
         if (tx_done) begin
            vectors++;
            if (done_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_tx_done: tx_done=1 owner=%0b, required no tx_done", tx_owner);
            end else begin
               mon_o = done_q.pop_front();
               if (tx_owner !== mon_o) begin
                  miscompares++;
                  $display("FAIL done_owner: tx_owner=%0b, required %0b", tx_owner, mon_o);
               end
            end
         end
         if (timeout_err) begin
            vectors++;
            if (to_expected == 0) begin
               miscompares++;
               $display("FAIL unexpected_timeout: timeout_err=1, required 0");
            end else begin
               to_expected--;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ack(input logic owner);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (((owner ? ack_b : ack_a) !== 1'b1) && n < 200);
      if (n >= 200) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_ack_%0d: no ack in 200 cycles, required an ack", owner);
      end
   endtask

   task automatic wait_strobe();
      int n;
      n = 0;
      while (TRANSMITTER_PRIZNAK !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      while (TRANSMITTER_PRIZNAK !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_strobe: strobe pulse not seen, required a strobe pulse");
      end
   endtask

   task automatic finish_frame();
      int n;
      tick(2);
      flag = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tx_done !== 1'b1 && n < 20);
      if (n >= 20) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_done: tx_done not seen in 20 cycles, required tx_done");
      end
      flag = 1'b0;
   endtask

   task automatic drive_frame();
      wait_strobe();
      finish_frame();
   endtask

   task automatic test_reset();
      res = 1'b0;
      tick(2);
      vectors++;
      if ({ack_a, ack_b, word_transmitter, TRANSMITTER_PRIZNAK, tx_done, tx_owner, timeout_err, busy} !== 15'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: busy=%0b word=%h strobe=%0b, required all zero", busy, word_transmitter, TRANSMITTER_PRIZNAK);
      end
      res = 1'b1;
      tick(2);
   endtask

   task automatic test_single();
      int n;
      word_a = 8'hA5;
      req_a  = 1'b1;
      grant_q.push_back('{1'b0, 8'hA5});
      done_q.push_back(1'b0);
      @(negedge clk);
      vectors++;
      if (ack_a !== 1'b1 || word_transmitter !== 8'hA5 || TRANSMITTER_PRIZNAK !== 1'b0) begin
         miscompares++;
         $display("FAIL single_ack: ack_a=%0b word=%h strobe=%0b, required 1 a5 0", ack_a, word_transmitter, TRANSMITTER_PRIZNAK);
      end
      req_a  = 1'b0;
      word_a = 8'hFF;
      @(negedge clk);
      n = 0;
      while (TRANSMITTER_PRIZNAK === 1'b1 && n < 50) begin
         n++;
         @(negedge clk);
      end
      vectors++;
      if (n != SH) begin
         miscompares++;
         $display("FAIL strobe_len: %0d cycles, required %0d", n, SH);
      end
      vectors++;
      if (word_transmitter !== 8'hA5 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL word_hold: word=%h busy=%0b, required a5 1", word_transmitter, busy);
      end
      finish_frame();
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_busy: busy=%0b, required 0", busy);
      end
   endtask

   task automatic test_tie();
      res = 1'b0;
      tick(2);
      res = 1'b1;
      tick(1);
      word_a = 8'h11;
      word_b = 8'h22;
      req_a  = 1'b1;
      req_b  = 1'b1;
      grant_q.push_back('{1'b0, 8'h11});
      grant_q.push_back('{1'b1, 8'h22});
      done_q.push_back(1'b0);
      done_q.push_back(1'b1);
      wait_ack(1'b0);
      req_a = 1'b0;
      drive_frame();
      wait_ack(1'b1);
      req_b = 1'b0;
      drive_frame();
   endtask

   task automatic test_alternate();
      logic o;
      word_b = 8'hB0;
      word_a = 8'hA0;
      req_a  = 1'b1;
      req_b  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         o = (i % 2 == 1);
         grant_q.push_back('{o, o ? 8'hB0 : 8'(8'hA0 + i)});
         done_q.push_back(o);
         wait_ack(o);
         if (!o) begin
            req_a = 1'b0;
            tick(1);
            word_a = 8'(8'hA0 + i + 2);
            req_a  = 1'b1;
         end else if (i == 3) begin
            req_a = 1'b0;
            req_b = 1'b0;
         end
         drive_frame();
      end
   endtask

   task automatic test_timeout();
      int n;
      word_a = 8'h5A;
      req_a  = 1'b1;
      grant_q.push_back('{1'b0, 8'h5A});
      wait_ack(1'b0);
      req_a = 1'b0;
      wait_strobe();
      word_b = 8'hC3;
      req_b  = 1'b1;
      grant_q.push_back('{1'b1, 8'hC3});
      done_q.push_back(1'b1);
      to_expected = 1;
      n = 0;
      while (timeout_err !== 1'b1 && n < TO + 20) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (n != TO) begin
         miscompares++;
         $display("FAIL timeout_delay: %0d cycles, required %0d", n, TO);
      end
      vectors++;
      if (busy !== 1'b0 || tx_done !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_state: busy=%0b tx_done=%0b, required 0 0", busy, tx_done);
      end
      @(negedge clk);
      vectors++;
      if (ack_b !== 1'b1) begin
         miscompares++;
         $display("FAIL pending_grant: ack_b=%0b, required 1", ack_b);
      end
      req_b = 1'b0;
      drive_frame();
   endtask

   task automatic test_reset_mid();
      int cnt;
      word_a = 8'h77;
      req_a  = 1'b1;
      grant_q.push_back('{1'b0, 8'h77});
      wait_ack(1'b0);
      req_a = 1'b0;
      wait_strobe();
      tick(3);
      #2 res = 1'b0;
      #1;
      vectors++;
      if ({ack_a, ack_b, word_transmitter, TRANSMITTER_PRIZNAK, tx_done, tx_owner, timeout_err, busy} !== 15'd0) begin
         miscompares++;
         $display("FAIL async_reset: busy=%0b word=%h owner=%0b, required all zero", busy, word_transmitter, tx_owner);
      end
      tick(2);
      res = 1'b1;
      tick(2);
      flag = 1'b1;
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (tx_done || timeout_err || busy || TRANSMITTER_PRIZNAK) cnt++;
      end
      flag = 1'b0;
      vectors++;
      if (cnt != 0) begin
         miscompares++;
         $display("FAIL post_reset_edge: %0d active cycles, required 0", cnt);
      end
   endtask

   task automatic test_idle_edge();
      int cnt;
      tick(2);
      flag = 1'b1;
      cnt  = 0;
      repeat (4) begin
         @(negedge clk);
         if (tx_done) cnt++;
      end
      flag = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (tx_done) cnt++;
      end
      vectors++;
      if (cnt != 0) begin
         miscompares++;
         $display("FAIL idle_edge: %0d tx_done pulses, required 0", cnt);
      end
      word_b = 8'h3C;
      req_b  = 1'b1;
      grant_q.push_back('{1'b1, 8'h3C});
      done_q.push_back(1'b1);
      wait_ack(1'b1);
      req_b = 1'b0;
      drive_frame();
      tick(2);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_alternate();
      test_timeout();
      test_reset_mid();
      test_idle_edge();
      vectors++;
      if (grant_q.size() != 0 || done_q.size() != 0 || to_expected != 0) begin
         miscompares++;
         $display("FAIL leftover: grants=%0d dones=%0d timeouts=%0d outstanding, required 0 0 0",
                  grant_q.size(), done_q.size(), to_expected);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter START_HOLD, default 8: clk cycles the start strobe stays high so the divided-clock transmitter samples it.
REQ-002 Parameter TIMEOUT, default 4096: clk cycles allowed in WAIT_END before abort.
REQ-003 Port clk  input  1  system clock; all state on its rising edge.
REQ-004 Port res  input  1  asynchronous, active-low reset.
REQ-005 Port req_a  input  1  requester A wants to send word_a; level, held until ack_a.
REQ-006 Port word_a  input  8  requester A data.
REQ-007 Port ack_a  output  1  one-cycle pulse: word_a latched, A may drop req_a.
REQ-008 Port req_b / word_b / ack_b: same as REQ-005..007 for requester B.
REQ-009 Port word_transmitter  output  8  latched word to the transmitter.
REQ-010 Port TRANSMITTER_PRIZNAK  output  1  start strobe to the transmitter.
REQ-011 Port priznak_end_transmitter  input  1  end-of-frame flag from the transmitter, in the clc domain.
REQ-012 Port tx_done  output  1  one-cycle pulse: frame completed.
REQ-013 Port tx_owner  output  1  owner of the current or last frame (0=A, 1=B); valid with tx_done.
REQ-014 Port timeout_err  output  1  one-cycle pulse: frame aborted on timeout.
REQ-015 Port busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, START, WAIT_END, DONE.
REQ-017 IDLE with any req high: grant one requester, latch its word into word_transmitter, pulse its ack, set tx_owner, go to START next cycle.
REQ-018 Arbitration is round-robin: on simultaneous req_a and req_b, grant the requester not granted last; a lone request is granted immediately.
REQ-019 START: drive TRANSMITTER_PRIZNAK high for exactly START_HOLD cycles, then go to WAIT_END.
REQ-020 priznak_end_transmitter passes through a 2-flop synchroniser; only its synchronised rising edge is used.
REQ-021 WAIT_END: on a synchronised rising edge of the end flag, go to DONE.
REQ-022 WAIT_END: on the TIMEOUT-th cycle without that edge, pulse timeout_err and go to IDLE; no tx_done.
REQ-023 DONE: pulse tx_done for one cycle, then go to IDLE.
REQ-024 Minimum gap from ack to the next ack is START_HOLD+4 cycles.
REQ-025 The grant is evaluated only in IDLE; requests arriving in other states wait without loss.
REQ-026 End-flag edges outside WAIT_END are ignored but still update the synchroniser edge history.
REQ-027 word_transmitter holds its value from latch until the next grant; changing word_x after ack has no effect.
REQ-028 Timeout counter width is clog2(TIMEOUT+1); it clears on entry to WAIT_END and does not wrap.

Reset
REQ-029 When res is low, go to IDLE and drive all outputs to 0.
REQ-030 Reset clears the synchroniser and counters, and sets the last grant to B so A wins the first tie.
REQ-031 Reset mid-frame abandons the frame: no tx_done and no timeout_err.

Structure
REQ-032 The shared package uart_pkg holds the state enum, the WORD_W=8 constant and the START_HOLD and TIMEOUT defaults.
REQ-033 One sub-module, uart_rr_pick, is combinational 2-way round-robin select (reqs and last grant in, grant one-hot out).

Verification
REQ-034 Only req_a, word_a=8'hA5 -> ack_a on the next cycle, word_transmitter=8'hA5, strobe high 8 cycles; end-flag edge -> tx_done with tx_owner=0.
REQ-035 req_a and req_b both high after reset -> A served first, then B without dropping either; tx_done pulses show owners 0,1.
REQ-036 B held high continuously and A re-requesting after each ack -> grants alternate A,B,A,B.
REQ-037 No end flag after the start strobe -> timeout_err exactly TIMEOUT cycles after WAIT_END entry, then IDLE; a pending req is granted next.
REQ-038 res pulled low during WAIT_END -> outputs 0 immediately, no tx_done; after release, an end-flag edge alone causes nothing.
REQ-039 End-flag edge while IDLE, then req_b with 8'h3C -> no spurious tx_done; frame completes normally with owner 1.
